// File: rtl/rbm_vote_argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbm_vote_argmax_pkg
// Description : Shared types, defaults and width helpers for the vote/argmax
//               block that follows the RBM classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package rbm_vote_argmax_pkg;

  // Decision state encoding
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int C_OUT_DIM_DEF   = 10;
  localparam int C_SAMPLE_BW_DEF = 12;
  localparam int C_ACC_BW_DEF    = 16;
  localparam int C_LABEL_BW_DEF  = 4;

  // Number of bits needed to hold values 0 .. v-1
  function automatic int clog2_f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Width of a flat packed vector of n elements of w bits each
  function automatic int packed_w(input int n, input int w);
    return n * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_vote_argmax_if.sv
`default_nettype none
// ============================================================================
// Module      : rbm_vote_argmax_if
// Description : Sample input, accumulator view and label handshake bundle.
//               Element j of the flat vectors sits at [j*W +: W].
// Revision    : 1.0 - initial release
// ============================================================================
interface rbm_vote_argmax_if
  import rbm_vote_argmax_pkg::*;
#(
  parameter int OUT_DIM          = C_OUT_DIM_DEF,
  parameter int SAMPLE_BITLENGTH = C_SAMPLE_BW_DEF,
  parameter int ACC_BITLENGTH    = C_ACC_BW_DEF,
  parameter int LABEL_BITLENGTH  = C_LABEL_BW_DEF
);
  logic [packed_w(OUT_DIM, SAMPLE_BITLENGTH)-1:0] SampleI;
  logic                                           sample_valid;
  logic                                           finish;
  logic [packed_w(OUT_DIM, ACC_BITLENGTH)-1:0]    CountO;
  logic [LABEL_BITLENGTH-1:0]                     label;
  logic [ACC_BITLENGTH-1:0]                       best_count;
  logic                                           label_valid;
  logic                                           label_ack;
  logic                                           busy;

  // Upstream classifier / label consumer side
  modport master (
    output SampleI, sample_valid, finish, label_ack,
    input  CountO, label, best_count, label_valid, busy
  );

  // Vote/argmax block side
  modport slave (
    input  SampleI, sample_valid, finish, label_ack,
    output CountO, label, best_count, label_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/rbm_vote_argmax_sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : rbm_sat_accum
// Description : One saturating accumulator with synchronous clear and enable.
//               Clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_sat_accum #(
  parameter int ACC_BITLENGTH    = 16,
  parameter int SAMPLE_BITLENGTH = 12
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        i_clr,
  input  wire logic                        i_en,
  input  wire logic [SAMPLE_BITLENGTH-1:0] i_sample,
  output logic      [ACC_BITLENGTH-1:0]    o_acc
);
  // One extra bit over the wider operand so the carry is never lost
  localparam int SUM_W = ((ACC_BITLENGTH > SAMPLE_BITLENGTH) ?
                          ACC_BITLENGTH : SAMPLE_BITLENGTH) + 1;
  localparam logic [SUM_W-1:0] C_MAX = SUM_W'({ACC_BITLENGTH{1'b1}});

  logic [ACC_BITLENGTH-1:0] acc_q;
  logic [ACC_BITLENGTH-1:0] acc_d;
  logic [SUM_W-1:0]         w_sum;

  assign w_sum = SUM_W'(acc_q) + SUM_W'(i_sample);

  // Next accumulator value: clear, saturating add, or hold
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = (w_sum > C_MAX) ? {ACC_BITLENGTH{1'b1}} : w_sum[ACC_BITLENGTH-1:0];
    end
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign o_acc = acc_q;
endmodule
`default_nettype wire

// File: rtl/rbm_vote_argmax.sv
`default_nettype none
// ============================================================================
// Module      : rbm_vote_argmax
// Description : Accumulates per-class classifier samples and, on finish,
//               scans the counters to report the winning label over a
//               valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_vote_argmax
  import rbm_vote_argmax_pkg::*;
#(
  parameter int OUT_DIM          = C_OUT_DIM_DEF,
  parameter int SAMPLE_BITLENGTH = C_SAMPLE_BW_DEF,
  parameter int ACC_BITLENGTH    = C_ACC_BW_DEF,
  parameter int LABEL_BITLENGTH  = C_LABEL_BW_DEF
) (
  input wire logic           clock,
  input wire logic           reset,
  rbm_vote_argmax_if.slave   bus
);
  // Scan index must also represent OUT_DIM, the "all elements fetched" value
  localparam int IDX_W = clog2_f(OUT_DIM + 1);

  logic [ACC_BITLENGTH-1:0]                    acc_w [OUT_DIM];
  logic [packed_w(OUT_DIM, ACC_BITLENGTH)-1:0] count_w;
  logic                                        acc_en_w;
  logic                                        acc_clr_w;
  logic [ACC_BITLENGTH-1:0]                    cand_sel_w;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ACC_BITLENGTH-1:0]   cand_q, cand_d;
  logic [IDX_W-1:0]           cand_idx_q, cand_idx_d;
  logic                       cand_vld_q, cand_vld_d;
  logic [LABEL_BITLENGTH-1:0] label_q, label_d;
  logic [ACC_BITLENGTH-1:0]   best_q, best_d;
  logic                       label_valid_q, label_valid_d;
  logic                       busy_q, busy_d;

  // Samples only count while accumulating; the ack of a label wipes the votes
  assign acc_en_w  = (state_q == ST_ACCUM) && bus.sample_valid;
  assign acc_clr_w = (state_q == ST_DONE) && bus.label_ack;

  generate
    for (genvar j = 0; j < OUT_DIM; j++) begin : g_acc
      rbm_sat_accum #(
        .ACC_BITLENGTH    (ACC_BITLENGTH),
        .SAMPLE_BITLENGTH (SAMPLE_BITLENGTH)
      ) u_acc (
        .clk      (clock),
        .rst      (reset),
        .i_clr    (acc_clr_w),
        .i_en     (acc_en_w),
        .i_sample (bus.SampleI[j*SAMPLE_BITLENGTH +: SAMPLE_BITLENGTH]),
        .o_acc    (acc_w[j])
      );
    end
  endgenerate

  // Flatten the accumulators onto the live count view
  always_comb begin
    count_w = '0;
    for (int j = 0; j < OUT_DIM; j++) begin
      count_w[j*ACC_BITLENGTH +: ACC_BITLENGTH] = acc_w[j];
    end
  end

  // Select the accumulator addressed by the scan index
  always_comb begin
    cand_sel_w = '0;
    for (int j = 0; j < OUT_DIM; j++) begin
      if (idx_q == IDX_W'(j)) cand_sel_w = acc_w[j];
    end
  end

  // Scan FSM next state: fetch one element per cycle into a candidate
  // register, compare it the following cycle (lower index wins ties)
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cand_d        = cand_q;
    cand_idx_d    = cand_idx_q;
    cand_vld_d    = 1'b0;
    label_d       = label_q;
    best_d        = best_q;
    label_valid_d = label_valid_q;
    busy_d        = busy_q;
    case (state_q)
      ST_ACCUM: begin
        if (bus.finish) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          best_d  = '0;
          label_d = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (idx_q < IDX_W'(OUT_DIM)) begin
          cand_d     = cand_sel_w;
          cand_idx_d = idx_q;
          cand_vld_d = 1'b1;
          idx_d      = idx_q + IDX_W'(1);
        end
        if (cand_vld_q) begin
          if (cand_q > best_q) begin
            best_d  = cand_q;
            label_d = LABEL_BITLENGTH'(cand_idx_q);
          end
          if (cand_idx_q == IDX_W'(OUT_DIM - 1)) begin
            state_d       = ST_DONE;
            label_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.label_ack) begin
          state_d       = ST_ACCUM;
          label_valid_d = 1'b0;
          busy_d        = 1'b0;
        end
      end
      default: begin
        state_d       = ST_ACCUM;
        label_valid_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // Scan FSM and registered outputs; reset aborts any scan in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ACCUM;
      idx_q         <= '0;
      cand_q        <= '0;
      cand_idx_q    <= '0;
      cand_vld_q    <= 1'b0;
      label_q       <= '0;
      best_q        <= '0;
      label_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cand_q        <= cand_d;
      cand_idx_q    <= cand_idx_d;
      cand_vld_q    <= cand_vld_d;
      label_q       <= label_d;
      best_q        <= best_d;
      label_valid_q <= label_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.CountO      = count_w;
  assign bus.label       = label_q;
  assign bus.best_count  = best_q;
  assign bus.label_valid = label_valid_q;
  assign bus.busy        = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_rbm_vote_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbm_vote_argmax
// Description : Self-checking bench for rbm_vote_argmax (default widths plus
//               a 4-bit accumulator instance for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbm_vote_argmax;
  localparam int OD      = 10;
  localparam int SB      = 12;
  localparam int AB      = 16;
  localparam int LB      = 4;
  localparam int AB4     = 4;
  localparam int ACC_MAX = (1 << AB) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rbm_vote_argmax_if #(.OUT_DIM(OD), .SAMPLE_BITLENGTH(SB),
                       .ACC_BITLENGTH(AB), .LABEL_BITLENGTH(LB)) bus ();
  rbm_vote_argmax_if #(.OUT_DIM(OD), .SAMPLE_BITLENGTH(SB),
                       .ACC_BITLENGTH(AB4), .LABEL_BITLENGTH(LB)) bus4 ();

  rbm_vote_argmax #(.OUT_DIM(OD), .SAMPLE_BITLENGTH(SB),
                    .ACC_BITLENGTH(AB), .LABEL_BITLENGTH(LB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  rbm_vote_argmax #(.OUT_DIM(OD), .SAMPLE_BITLENGTH(SB),
                    .ACC_BITLENGTH(AB4), .LABEL_BITLENGTH(LB)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct packed {
    logic [LB-1:0]    lbl;
    logic [AB-1:0]    best;
    logic [OD*AB-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_acc [OD];
  logic lv_prev = 1'b0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [OD*AB-1:0] model_pack();
    logic [OD*AB-1:0] r;
    r = '0;
    for (int j = 0; j < OD; j++) r[j*AB +: AB] = AB'(m_acc[j]);
    return r;
  endfunction

  // Winner = first class holding the largest vote total
  function automatic exp_t model_expect();
    exp_t e;
    int   best;
    int   lbl;
    best = 0;
    lbl  = 0;
    for (int j = 0; j < OD; j++) begin
      if (m_acc[j] > best) begin
        best = m_acc[j];
        lbl  = j;
      end
    end
    e.lbl  = LB'(lbl);
    e.best = AB'(best);
    e.cnt  = model_pack();
    return e;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < OD; j++) m_acc[j] = 0;
  endtask

  function automatic logic [OD*SB-1:0] one_hot_vec(input int idx, input int val);
    logic [OD*SB-1:0] r;
    r = '0;
    r[idx*SB +: SB] = SB'(val);
    return r;
  endfunction

  function automatic logic [OD*SB-1:0] rand_vec(input int mode);
    logic [OD*SB-1:0] r;
    int v;
    for (int j = 0; j < OD; j++) begin
      if (mode == 0)      v = $urandom_range(0, 3);
      else if (mode == 1) v = $urandom_range(0, 4095);
      else                v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      r[j*SB +: SB] = SB'(v);
    end
    return r;
  endfunction

  // One cycle of stimulus on the main instance
  task automatic drive(input bit sv, input logic [OD*SB-1:0] v, input bit fin);
    bus.SampleI      = v;
    bus.sample_valid = sv;
    bus.finish       = fin;
    @(posedge clock);
    #1;
    bus.sample_valid = 1'b0;
    bus.finish       = 1'b0;
    if (sv) begin
      for (int j = 0; j < OD; j++) begin
        m_acc[j] = m_acc[j] + int'(v[j*SB +: SB]);
        if (m_acc[j] > ACC_MAX) m_acc[j] = ACC_MAX;
      end
    end
    if (fin) exp_q.push_back(model_expect());
  endtask

  // Edges from the finish edge until label_valid is seen
  task automatic wait_label(input int lat);
    int n;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.label_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("label_latency", n, lat);
  endtask

  task automatic ack();
    bus.label_ack = 1'b1;
    @(posedge clock);
    #1;
    bus.label_ack = 1'b0;
    model_clear();
    chk("ack_label_valid", bus.label_valid, 0);
    chk("ack_countO", bus.CountO, 0);
    chk("ack_busy", bus.busy, 0);
  endtask

  // Monitor: compare each newly presented label against the scoreboard
  always @(negedge clock) begin
    if (bus.label_valid === 1'b1 && !lv_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_label", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_label", bus.label, mon_e.lbl);
        chk("sb_best_count", bus.best_count, mon_e.best);
        chk("sb_countO", bus.CountO, mon_e.cnt);
      end
    end
    lv_prev = (bus.label_valid === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lv_seen;
    int   n;
    logic [LB-1:0] held_lbl;
    logic [AB-1:0] held_best;

    model_clear();
    reset = 1'b1;
    bus.SampleI = '0;  bus.sample_valid = 1'b0;  bus.finish = 1'b0;  bus.label_ack = 1'b0;
    bus4.SampleI = '0; bus4.sample_valid = 1'b0; bus4.finish = 1'b0; bus4.label_ack = 1'b0;
    #2;
    chk("rst_countO", bus.CountO, 0);
    chk("rst_label", bus.label, 0);
    chk("rst_best_count", bus.best_count, 0);
    chk("rst_label_valid", bus.label_valid, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset during a scan aborts it
    drive(1, one_hot_vec(1, 7), 0);
    drive(1, one_hot_vec(1, 7), 0);
    chk("pre_abort_countO", bus.CountO, model_pack());
    drive(0, '0, 1);
    repeat (4) @(posedge clock);
    #2;
    chk("scan_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_countO", bus.CountO, 0);
    chk("abort_label_valid", bus.label_valid, 0);
    chk("abort_busy", bus.busy, 0);
    void'(exp_q.pop_back());
    model_clear();
    @(posedge clock);
    #1 reset = 1'b0;
    lv_seen = 0;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (bus.label_valid !== 1'b0) lv_seen++;
    end
    chk("abort_no_label", lv_seen, 0);
    drive(1, one_hot_vec(4, 3), 0);
    drive(1, one_hot_vec(4, 3), 0);
    chk("post_abort_countO", bus.CountO, model_pack());
    drive(0, '0, 1);
    wait_label(11);
    ack();

    // Five votes for class 3
    repeat (5) drive(1, one_hot_vec(3, 1), 0);
    drive(0, '0, 1);
    wait_label(11);
    chk("t2_countO3", bus.CountO[3*AB +: AB], 5);
    ack();

    // Tie between classes 2 and 7
    repeat (4) drive(1, one_hot_vec(2, 1) | one_hot_vec(7, 1), 0);
    drive(0, '0, 1);
    wait_label(11);
    ack();

    // Sample and finish together, then samples during the scan are ignored
    drive(1, one_hot_vec(9, 1), 1);
    bus.SampleI = rand_vec(1) | one_hot_vec(0, 100);
    bus.sample_valid = 1'b1;
    bus.finish = 1'b1;
    @(posedge clock);
    #1;
    bus.sample_valid = 1'b0;
    bus.finish = 1'b0;
    chk("scan_ignore_countO", bus.CountO, model_pack());
    wait_label(10);

    // Handshake: label held while ack is low
    held_lbl  = bus.label;
    held_best = bus.best_count;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.label_valid !== 1'b1 || bus.label !== held_lbl || bus.best_count !== held_best) n++;
    end
    chk("hold_stable", n, 0);
    chk("hold_label", bus.label, 9);
    ack();
    chk("after_ack_label_kept", bus.label, 9);
    chk("after_ack_best_kept", bus.best_count, 1);
    drive(1, one_hot_vec(5, 2), 0);
    drive(0, '0, 1);
    wait_label(11);
    ack();

    // All classes saturate: tie at full scale goes to class 0
    repeat (17) drive(1, {OD{12'hFFF}}, 0);
    chk("sat16_countO", bus.CountO, {OD{16'hFFFF}});
    drive(0, '0, 1);
    wait_label(11);
    ack();

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int ns;
      int mode;
      ns = $urandom_range(1, 20);
      mode = $urandom_range(0, 2);
      for (int s = 0; s < ns - 1; s++) drive(1, rand_vec(mode), 0);
      if ($urandom_range(0, 1) == 1) begin
        drive(1, rand_vec(mode), 1);
      end else begin
        drive(1, rand_vec(mode), 0);
        chk("rand_countO", bus.CountO, model_pack());
        drive(0, '0, 1);
      end
      wait_label(11);
      repeat ($urandom_range(0, 5)) @(posedge clock);
      #1;
      ack();
    end

    // 4-bit accumulator saturation on the second instance
    repeat (3) begin
      bus4.SampleI = one_hot_vec(0, 12);
      bus4.sample_valid = 1'b1;
      @(posedge clock);
      #1;
      bus4.sample_valid = 1'b0;
    end
    chk("sat4_countO0", bus4.CountO[AB4-1:0], 15);
    bus4.finish = 1'b1;
    @(posedge clock);
    #1;
    bus4.finish = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (bus4.label_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("sat4_latency", n, 11);
    chk("sat4_label", bus4.label, 0);
    chk("sat4_best_count", bus4.best_count, 15);
    bus4.label_ack = 1'b1;
    @(posedge clock);
    #1;
    bus4.label_ack = 1'b0;
    chk("sat4_ack_countO", bus4.CountO, 0);

    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
